// File: rtl/conv_ram_arbiter.sv
// conv_ram_arbiter: two-port arbiter in front of a single-port RAM with
// registered output (1-cycle read latency). Port A is the host loader,
// port B is the NPU conv engine.
// Optional burst locking is compiled in with `define CONV_ARB_LOCK_EN;
// without it lock_a/lock_b are ignored and the block is pure round-robin.
module conv_ram_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic              lock_a,
  input  logic              lock_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  // r_last_b = 1 means B won most recently, so A is favoured next.
  logic r_last_b;
  logic r_rvalid_a;
  logic r_rvalid_b;
  logic w_hold_a;
  logic w_hold_b;
  logic w_gnt_a;
  logic w_gnt_b;

`ifdef CONV_ARB_LOCK_EN
  localparam logic [1:0] ST_RR     = 2'd0;
  localparam logic [1:0] ST_LOCK_A = 2'd1;
  localparam logic [1:0] ST_LOCK_B = 2'd2;
  localparam int         CNT_W     = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] r_lock_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // A lock only holds while its owner keeps both req and lock up; the
  // cycle either falls the arbiter already behaves as round-robin.
  assign w_hold_a = (r_state == ST_LOCK_A) && req_a && lock_a;
  assign w_hold_b = (r_state == ST_LOCK_B) && req_b && lock_b;

  // Next state and lock counter; the grant that reaches MAX_LOCK releases.
  always_comb begin
    w_state_next = ST_RR;
    w_cnt_next   = '0;
    if (w_hold_a) begin
      if (r_lock_cnt < CNT_LAST) begin
        w_state_next = ST_LOCK_A;
        w_cnt_next   = r_lock_cnt + CNT_ONE;
      end
    end else if (w_hold_b) begin
      if (r_lock_cnt < CNT_LAST) begin
        w_state_next = ST_LOCK_B;
        w_cnt_next   = r_lock_cnt + CNT_ONE;
      end
    end else if (r_state == ST_RR) begin
      if (w_gnt_a && lock_a && (MAX_LOCK > 1)) begin
        w_state_next = ST_LOCK_A;
        w_cnt_next   = CNT_ONE;
      end else if (w_gnt_b && lock_b && (MAX_LOCK > 1)) begin
        w_state_next = ST_LOCK_B;
        w_cnt_next   = CNT_ONE;
      end
    end
  end

  // Lock state register; reset aborts any burst in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RR;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_lock_cnt <= w_cnt_next;
    end
  end
`else
  assign w_hold_a = 1'b0;
  assign w_hold_b = 1'b0;
  logic w_unused_lock;
  assign w_unused_lock = lock_a | lock_b | (MAX_LOCK == 0);
`endif

  // Grant decision: lock holder first, otherwise round-robin; none in reset.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!reset) begin
      if (w_hold_a) begin
        w_gnt_a = 1'b1;
      end else if (w_hold_b) begin
        w_gnt_b = 1'b1;
      end else if (req_a && (!req_b || r_last_b)) begin
        w_gnt_a = 1'b1;
      end else if (req_b) begin
        w_gnt_b = 1'b1;
      end
    end
  end

  // Round-robin pointer tracks the winner of every grant, locked or not.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_b <= 1'b1;
    end else if (w_gnt_a) begin
      r_last_b <= 1'b0;
    end else if (w_gnt_b) begin
      r_last_b <= 1'b1;
    end
  end

  // Read-valid strobes line up with the RAM's one-cycle read latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
    end else begin
      r_rvalid_a <= w_gnt_a && !we_a;
      r_rvalid_b <= w_gnt_b && !we_b;
    end
  end

  // RAM mux: the winner drives the RAM, idle cycles drive zeros.
  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    if (w_gnt_a) begin
      ram_address = addr_a;
      ram_data    = wdata_a;
      ram_wren    = we_a;
    end else if (w_gnt_b) begin
      ram_address = addr_b;
      ram_data    = wdata_b;
      ram_wren    = we_b;
    end
  end

  assign gnt_a    = w_gnt_a;
  assign gnt_b    = w_gnt_b;
  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;
  assign rdata_a  = ram_q;
  assign rdata_b  = ram_q;

endmodule

// File: tb/tb_conv_ram_arbiter.sv
// Testbench for conv_ram_arbiter: a behavioural RAM plus a reference model
// of the arbitration rules, driven by directed scenarios and random traffic.
module tb_conv_ram_arbiter;
  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 8;
  localparam int MAX_LOCK = 64;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_a, req_b, we_a, we_b, lock_a, lock_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] wdata_a, wdata_b;
  logic              gnt_a, gnt_b, rvalid_a, rvalid_b, ram_wren;
  logic [DATA_W-1:0] rdata_a, rdata_b, ram_data;
  logic [DATA_W-1:0] ram_q = '0;
  logic [ADDR_W-1:0] ram_address;

  conv_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .lock_a(lock_a), .lock_b(lock_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // Single-port RAM with registered output; same-cycle read returns old data.
  logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
  always @(posedge clock) begin
    ram_q <= ram_mem[ram_address];
    if (ram_wren) ram_mem[ram_address] <= ram_data;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (plain integers, not the RTL's encoding).
  int          m_owner;   // 0 none, 1 A holds a lock, 2 B holds a lock
  int          m_count;   // grants delivered in the current lock
  int          m_last;    // 1 A won last, 2 B won last
  bit          m_pend_a, m_pend_b;
  logic [7:0]  m_pend_data;
  logic [7:0]  exp_mem [int];
  int          last_g;    // winner of the most recent step: 0 none, 1 A, 2 B

  function automatic logic [7:0] preload(input logic [13:0] a);
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  function automatic logic [7:0] model_read(input logic [13:0] a);
    if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
    return preload(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_count = 0; m_last = 2; m_pend_a = 0; m_pend_b = 0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input logic ra, input logic wa, input logic [13:0] aa,
                      input logic [7:0] da, input logic la,
                      input logic rb, input logic wb, input logic [13:0] ab,
                      input logic [7:0] db, input logic lb, input bit rst_mid);
    logic ga, gb, hold_a, hold_b;
    @(negedge clock);
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da; lock_a = la;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db; lock_b = lb;
    #1;
    check("rvalid_a", 32'(rvalid_a), 32'(m_pend_a));
    check("rvalid_b", 32'(rvalid_b), 32'(m_pend_b));
    if (m_pend_a) check("rdata_a", 32'(rdata_a), 32'(m_pend_data));
    if (m_pend_b) check("rdata_b", 32'(rdata_b), 32'(m_pend_data));
    hold_a = (m_owner == 1) && ra && la;
    hold_b = (m_owner == 2) && rb && lb;
    ga = 0; gb = 0;
    if (hold_a) ga = 1;
    else if (hold_b) gb = 1;
    else if (ra && rb) begin ga = (m_last == 2); gb = !ga; end
    else begin ga = ra; gb = rb; end
    check("gnt_a", 32'(gnt_a), 32'(ga));
    check("gnt_b", 32'(gnt_b), 32'(gb));
    check("ram_wren", 32'(ram_wren), 32'(ga ? wa : (gb ? wb : 1'b0)));
    check("ram_address", 32'(ram_address), 32'(ga ? aa : (gb ? ab : 14'h0)));
    check("ram_data", 32'(ram_data), 32'(ga ? da : (gb ? db : 8'h0)));
    last_g = ga ? 1 : (gb ? 2 : 0);
    if (rst_mid) begin
      #1 reset = 1'b1;
      #1;
      check("rst_gnt_a", 32'(gnt_a), 32'(0));
      check("rst_gnt_b", 32'(gnt_b), 32'(0));
      check("rst_wren", 32'(ram_wren), 32'(0));
      check("rst_rvalid_b", 32'(rvalid_b), 32'(0));
      @(posedge clock);
      #1;
      check("rst_rvalid_b_hold", 32'(rvalid_b), 32'(0));
      check("rst_rvalid_a_hold", 32'(rvalid_a), 32'(0));
`ifdef CONV_ARB_LOCK_EN
      check("rst_state", 32'(dut.r_state), 32'(0));
      check("rst_lock_cnt", 32'(dut.r_lock_cnt), 32'(0));
`endif
      @(negedge clock);
      req_a = 0; req_b = 0; reset = 1'b0;
      model_reset();
      return;
    end
    m_pend_a = ga && !wa;
    m_pend_b = gb && !wb;
    if (m_pend_a) m_pend_data = model_read(aa);
    if (m_pend_b) m_pend_data = model_read(ab);
    if (ga && wa) exp_mem[int'(aa)] = da;
    if (gb && wb) exp_mem[int'(ab)] = db;
`ifdef CONV_ARB_LOCK_EN
    if (hold_a || hold_b) begin
      m_count++;
      if (m_count >= MAX_LOCK) begin m_owner = 0; m_count = 0; end
    end else if (m_owner != 0) begin
      m_owner = 0; m_count = 0;
    end else if (ga && la && MAX_LOCK > 1) begin
      m_owner = 1; m_count = 1;
    end else if (gb && lb && MAX_LOCK > 1) begin
      m_owner = 2; m_count = 1;
    end
`endif
    if (ga) m_last = 1;
    if (gb) m_last = 2;
  endtask

  task automatic idle();
    step(0, 0, 14'h0, 8'h0, 0, 0, 0, 14'h0, 8'h0, 0, 0);
  endtask

  int run_b;
  bit a_seen;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram_mem[i] = preload(14'(i));
    model_reset();
    last_g = 0;
    // Reset: requests present but nothing may be granted or written.
    req_a = 1; req_b = 1; we_a = 1; we_b = 1; lock_a = 1; lock_b = 1;
    addr_a = 14'h0123; addr_b = 14'h0456; wdata_a = 8'h11; wdata_b = 8'h22;
    repeat (2) @(posedge clock);
    #1;
    check("reset_gnt_a", 32'(gnt_a), 32'(0));
    check("reset_gnt_b", 32'(gnt_b), 32'(0));
    check("reset_wren", 32'(ram_wren), 32'(0));
    check("reset_addr", 32'(ram_address), 32'(0));
    check("reset_rvalid_a", 32'(rvalid_a), 32'(0));
    check("reset_rvalid_b", 32'(rvalid_b), 32'(0));
`ifdef CONV_ARB_LOCK_EN
    check("reset_lock_cnt", 32'(dut.r_lock_cnt), 32'(0));
`endif
    @(negedge clock);
    req_a = 0; req_b = 0; reset = 0;

    // Contending reads alternate starting with A.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 14'h0010, 8'h0, 0, 1, 0, 14'h0020, 8'h0, 0, 0);
      check("alt_winner", 32'(last_g), 32'((i % 2 == 0) ? 1 : 2));
    end
    idle();

    // B alone: write then read back the top address.
    step(0, 0, 14'h0, 8'h0, 0, 1, 1, 14'h3FFF, 8'h5A, 0, 0);
    step(0, 0, 14'h0, 8'h0, 0, 1, 0, 14'h3FFF, 8'h00, 0, 0);
    idle();

    // Random traffic with hazards on a small address set.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
           ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom_range(0, 7)),
           8'($urandom), $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
           ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom_range(0, 7)),
           8'($urandom), $urandom_range(0, 9) != 0, 0);
    end
    idle();
    idle();

    // B holds its lock while A keeps requesting: forced release after MAX_LOCK.
    step(0, 0, 14'h0, 8'h0, 0, 1, 0, 14'h0020, 8'h0, 1, 0);
    run_b = (last_g == 2) ? 1 : 0;
    a_seen = 0;
    for (int i = 0; i < MAX_LOCK + 2; i++) begin
      step(1, 0, 14'h0010, 8'h0, 0, 1, 0, 14'(i), 8'h0, 1, 0);
      if (last_g == 1) a_seen = 1;
      if (!a_seen && last_g == 2) run_b++;
      if (last_g == 1 && i == MAX_LOCK - 1) begin
`ifdef CONV_ARB_LOCK_EN
        #5 check("forced_release_state", 32'(dut.r_state), 32'(0));
`endif
      end
    end
`ifdef CONV_ARB_LOCK_EN
    check("lock_run", 32'(run_b), 32'(MAX_LOCK));
`else
    check("lock_run", 32'(run_b), 32'(1));
`endif
    idle();

    // B drops its lock after five locked grants: A wins at once.
    step(0, 0, 14'h0, 8'h0, 0, 1, 1, 14'h0100, 8'h77, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 14'h0100, 8'h0, 0, 1, 1, 14'h0101, 8'h33, 1, 0);
    step(1, 0, 14'h0100, 8'h0, 0, 1, 0, 14'h0101, 8'h0, 0, 0);
    check("drop_gnt_a", 32'(last_g), 32'(1));
`ifdef CONV_ARB_LOCK_EN
    #6;
    check("drop_lock_cnt", 32'(dut.r_lock_cnt), 32'(0));
    check("drop_state", 32'(dut.r_state), 32'(0));
`endif
    idle();

    // Reset in the middle of a B burst right after a granted B read.
    step(0, 0, 14'h0, 8'h0, 0, 1, 0, 14'h0200, 8'h0, 1, 0);
    step(1, 0, 14'h0201, 8'h0, 0, 1, 0, 14'h0202, 8'h0, 1, 0);
    step(0, 0, 14'h0, 8'h0, 0, 1, 0, 14'h0203, 8'h0, 1, 1);
    step(1, 0, 14'h0010, 8'h0, 0, 1, 0, 14'h0020, 8'h0, 0, 0);
    check("post_reset_a_first", 32'(last_g), 32'(1));
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
